// File: rtl/memory_access.sv
// Memory-access pipeline stage: forwards ALU results, runs one data-bus
// transfer per load/store, and aligns/extends load data for writeback.
module memory_access #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [31:0]       ex_alu_result,
    input  logic [31:0]       ex_store_data,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [1:0]        ex_size,
    input  logic              ex_unsigned,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [31:0]       dbus_wdata,
    output logic [3:0]        dbus_be,
    input  logic [31:0]       dbus_rdata,
    input  logic              dbus_ack,
    output logic [31:0]       wb_result,
    output logic [4:0]        wb_rd,
    output logic              wb_reg_write,
    output logic              mem_fault
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_W   = 5;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_e              state_q, state_d;
    logic                dbus_req_q, dbus_req_d;
    logic                dbus_we_q, dbus_we_d;
    logic [ADDR_W-1:0]   dbus_addr_q, dbus_addr_d;
    logic [DATA_W-1:0]   dbus_wdata_q, dbus_wdata_d;
    logic [3:0]          dbus_be_q, dbus_be_d;
    logic [DATA_W-1:0]   wb_result_q, wb_result_d;
    logic [RD_W-1:0]     wb_rd_q, wb_rd_d;
    logic                wb_reg_write_q, wb_reg_write_d;
    logic                mem_fault_q, mem_fault_d;
    // Context of the outstanding transfer, needed when the ack arrives
    logic [1:0]          pend_off_q, pend_off_d;
    logic [1:0]          pend_size_q, pend_size_d;
    logic                pend_uns_q, pend_uns_d;
    logic                pend_load_q, pend_load_d;
    logic [RD_W-1:0]     pend_rd_q, pend_rd_d;
    logic                pend_wr_q, pend_wr_d;

    logic                accept_c;
    logic                is_mem_c;
    logic                fault_c;
    logic                rd_we_c;
    logic [1:0]          off_c;
    logic [3:0]          be_c;
    logic [DATA_W-1:0]   wdata_c;
    logic [DATA_W-1:0]   lane_c;
    logic [DATA_W-1:0]   load_c;

    assign ex_ready = (state_q == IDLE);
    assign accept_c = ex_valid & ex_ready;
    assign is_mem_c = ex_mem_read | ex_mem_write;
    assign rd_we_c  = ex_reg_write & (ex_rd != RD_W'(0));
    assign off_c    = ex_alu_result[1:0];

    // Misalignment / illegal-encoding detection for the incoming memory op
    always_comb begin
        fault_c = 1'b0;
        if (ex_size == 2'b11)                       fault_c = 1'b1;
        if ((ex_size == SZ_HALF) && off_c[0])       fault_c = 1'b1;
        if ((ex_size == SZ_WORD) && (off_c != 2'b00)) fault_c = 1'b1;
        if (ex_mem_read && ex_mem_write)            fault_c = 1'b1;
    end

    // Byte enables and lane-replicated store data
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = ex_store_data;
        case (ex_size)
            SZ_BYTE: begin
                be_c    = 4'b0001 << off_c;
                wdata_c = {4{ex_store_data[7:0]}};
            end
            SZ_HALF: begin
                be_c    = 4'b0011 << off_c;
                wdata_c = {2{ex_store_data[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = ex_store_data;
            end
        endcase
    end

    // Load lane select and sign/zero extension
    always_comb begin
        lane_c = dbus_rdata >> {pend_off_q, 3'b000};
        case (pend_size_q)
            SZ_BYTE: load_c = pend_uns_q ? {24'b0, lane_c[7:0]}
                                         : {{24{lane_c[7]}}, lane_c[7:0]};
            SZ_HALF: load_c = pend_uns_q ? {16'b0, lane_c[15:0]}
                                         : {{16{lane_c[15]}}, lane_c[15:0]};
            default: load_c = lane_c;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d        = state_q;
        dbus_req_d     = dbus_req_q;
        dbus_we_d      = dbus_we_q;
        dbus_addr_d    = dbus_addr_q;
        dbus_wdata_d   = dbus_wdata_q;
        dbus_be_d      = dbus_be_q;
        wb_result_d    = wb_result_q;
        wb_rd_d        = wb_rd_q;
        wb_reg_write_d = 1'b0;
        mem_fault_d    = 1'b0;
        pend_off_d     = pend_off_q;
        pend_size_d    = pend_size_q;
        pend_uns_d     = pend_uns_q;
        pend_load_d    = pend_load_q;
        pend_rd_d      = pend_rd_q;
        pend_wr_d      = pend_wr_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (!is_mem_c) begin
                        wb_result_d    = ex_alu_result;
                        wb_rd_d        = ex_rd;
                        wb_reg_write_d = rd_we_c;
                    end else if (fault_c) begin
                        mem_fault_d    = 1'b1;
                    end else begin
                        state_d      = BUS;
                        dbus_req_d   = 1'b1;
                        dbus_we_d    = ex_mem_write;
                        dbus_addr_d  = {ex_alu_result[ADDR_W-1:2], 2'b00};
                        dbus_wdata_d = wdata_c;
                        dbus_be_d    = be_c;
                        pend_off_d   = off_c;
                        pend_size_d  = ex_size;
                        pend_uns_d   = ex_unsigned;
                        pend_load_d  = ex_mem_read;
                        pend_rd_d    = ex_rd;
                        pend_wr_d    = rd_we_c;
                    end
                end
            end
            BUS: begin
                if (dbus_ack) begin
                    state_d    = IDLE;
                    dbus_req_d = 1'b0;
                    if (pend_load_q) begin
                        wb_result_d    = load_c;
                        wb_rd_d        = pend_rd_q;
                        wb_reg_write_d = pend_wr_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            dbus_req_q     <= 1'b0;
            dbus_we_q      <= 1'b0;
            dbus_addr_q    <= '0;
            dbus_wdata_q   <= '0;
            dbus_be_q      <= '0;
            wb_result_q    <= '0;
            wb_rd_q        <= '0;
            wb_reg_write_q <= 1'b0;
            mem_fault_q    <= 1'b0;
            pend_off_q     <= '0;
            pend_size_q    <= '0;
            pend_uns_q     <= 1'b0;
            pend_load_q    <= 1'b0;
            pend_rd_q      <= '0;
            pend_wr_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            dbus_req_q     <= dbus_req_d;
            dbus_we_q      <= dbus_we_d;
            dbus_addr_q    <= dbus_addr_d;
            dbus_wdata_q   <= dbus_wdata_d;
            dbus_be_q      <= dbus_be_d;
            wb_result_q    <= wb_result_d;
            wb_rd_q        <= wb_rd_d;
            wb_reg_write_q <= wb_reg_write_d;
            mem_fault_q    <= mem_fault_d;
            pend_off_q     <= pend_off_d;
            pend_size_q    <= pend_size_d;
            pend_uns_q     <= pend_uns_d;
            pend_load_q    <= pend_load_d;
            pend_rd_q      <= pend_rd_d;
            pend_wr_q      <= pend_wr_d;
        end
    end

    assign dbus_req     = dbus_req_q;
    assign dbus_we      = dbus_we_q;
    assign dbus_addr    = dbus_addr_q;
    assign dbus_wdata   = dbus_wdata_q;
    assign dbus_be      = dbus_be_q;
    assign wb_result    = wb_result_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_reg_write_q;
    assign mem_fault    = mem_fault_q;

endmodule
